// File: rtl/ifft_out_reorder_pkg.sv
// ifft_out_reorder_pkg: shared widths, state encoding and bit-reverse helper for IFFT reorder logic
package ifft_out_reorder_pkg;
  localparam int DEF_INTEGER_SIZE = 16;
  localparam int DEF_FRACT_SIZE = 16;
  localparam int DEF_NFFT = 128;
  localparam int DATA_WIDTH = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;
  localparam int ADDR_WIDTH = $clog2(DEF_NFFT);
  localparam int MAX_ADDR_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPTURE = 2'd1,
    DRAIN = 2'd2
  } state_t;
  // Reverses the low w bits of k; bits at and above w come back as zero.
  function automatic logic [MAX_ADDR_WIDTH-1:0] bit_rev(input logic [MAX_ADDR_WIDTH-1:0] k, input int w);
    logic [MAX_ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++)
      if (i < w) r[w-1-i] = k[i];
    return r;
  endfunction
endpackage

// File: rtl/ifft_frame_ram.sv
// ifft_frame_ram: frame buffer with one synchronous write port and one asynchronous read port
module ifft_frame_ram
  import ifft_out_reorder_pkg::*;
#(
  parameter int W = 2 * DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ifft_out_reorder.sv
// ifft_out_reorder: captures a bit-reversed IFFT frame and replays it in natural order on a valid/ready stream
module ifft_out_reorder
  import ifft_out_reorder_pkg::*;
#(
  parameter int INTEGER_SIZE = DEF_INTEGER_SIZE,
  parameter int FRACT_SIZE = DEF_FRACT_SIZE,
  parameter int NFFT = DEF_NFFT,
  parameter int BIT_REVERSE = 1,
  localparam int DW = INTEGER_SIZE + FRACT_SIZE,
  localparam int AW = $clog2(NFFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  input  logic                 in_valid,
  input  logic                 in_first,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [AW-1:0]        out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 err_clr
);
  state_t state, state_nxt;
  logic [AW-1:0] cnt, rd_idx, wr_k, wr_addr;
  logic [2*DW-1:0] rd_data;
  logic xfer, xfer_last, wr_first, wr_en, cap_done;
  // A new frame may start in IDLE, restart in CAPTURE, or overlap the final drain transfer.
  always_comb begin
    xfer = (state == DRAIN) && out_ready;
    xfer_last = xfer && (rd_idx == AW'(NFFT - 1));
    wr_first = in_valid && in_first && (state != DRAIN || xfer_last);
    wr_en = wr_first || (in_valid && state == CAPTURE);
    wr_k = wr_first ? '0 : cnt;
    wr_addr = (BIT_REVERSE != 0) ? AW'(bit_rev(MAX_ADDR_WIDTH'(wr_k), AW)) : wr_k;
    cap_done = wr_en && !wr_first && (cnt == AW'(NFFT - 1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = wr_first ? CAPTURE : IDLE;
      CAPTURE: state_nxt = cap_done ? DRAIN : CAPTURE;
      DRAIN:   state_nxt = xfer_last ? (wr_first ? CAPTURE : IDLE) : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    out_valid = (state == DRAIN);
    busy = (state != IDLE);
    out_last = out_valid && (rd_idx == AW'(NFFT - 1));
    out_index = out_valid ? rd_idx : '0;
    out_r = out_valid ? $signed(rd_data[2*DW-1:DW]) : '0;
    out_i = out_valid ? $signed(rd_data[DW-1:0]) : '0;
  end
  // Error flags: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rd_idx <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cnt <= wr_en ? wr_k + AW'(1) : cnt;
      rd_idx <= xfer_last ? '0 : (xfer ? rd_idx + AW'(1) : rd_idx);
      frame_err <= (state == CAPTURE && in_valid && in_first) || (frame_err && !err_clr);
      overflow <= (state == DRAIN && in_valid && !wr_first) || (overflow && !err_clr);
    end
  ifft_frame_ram #(
    .W(2 * DW),
    .AW(AW),
    .DEPTH(NFFT)
  ) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_addr),
    .wdata({in_r, in_i}),
    .raddr(rd_idx),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_ifft_out_reorder.sv
// tb_ifft_out_reorder: randomized self-checking bench against a natural-order frame model
module tb_ifft_out_reorder;
  localparam int N = 128;
  logic clk_tb = 1'b0;
  logic rst, in_valid, in_first, out_ready, err_clr;
  logic out_valid, out_last, busy, frame_err, overflow;
  logic [31:0] in_r, in_i, out_r, out_i;
  logic [6:0] out_index;
  logic [31:0] fr_r [N], fr_i [N], ex_r [N], ex_i [N];
  int n_cmp = 0, n_err = 0;
  always #5 clk_tb = ~clk_tb;
  ifft_out_reorder #(
    .INTEGER_SIZE(16),
    .FRACT_SIZE(16),
    .NFFT(N),
    .BIT_REVERSE(1)
  ) dut (
    .clk(clk_tb),
    .rst(rst),
    .in_r(in_r),
    .in_i(in_i),
    .in_valid(in_valid),
    .in_first(in_first),
    .out_r(out_r),
    .out_i(out_i),
    .out_index(out_index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .frame_err(frame_err),
    .overflow(overflow),
    .err_clr(err_clr)
  );
  function automatic int rev7(int k);
    int r = 0;
    for (int i = 0; i < 7; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic fill(bit ramp);
    for (int k = 0; k < N; k++) begin
      fr_r[k] = ramp ? 32'(k) << 16 : $urandom;
      fr_i[k] = ramp ? 32'(-k) : $urandom;
    end
  endtask
  // Natural output n carries the sample that arrived at stream position rev7(n).
  task automatic set_expected();
    for (int n = 0; n < N; n++) begin
      ex_r[n] = fr_r[rev7(n)];
      ex_i[n] = fr_i[rev7(n)];
    end
  endtask
  task automatic send(int from, int to, int gap_max, bit first_at_from);
    for (int k = from; k <= to; k++) begin
      if (gap_max > 0)
        repeat ($urandom_range(gap_max, 1)) begin
          @(negedge clk_tb);
          in_valid = 1'b0;
          in_first = 1'b0;
        end
      @(negedge clk_tb);
      in_valid = 1'b1;
      in_first = (k == from) && first_at_from;
      in_r = fr_r[k];
      in_i = fr_i[k];
      if (k == N - 1) begin
        #1;
        check("pre_valid", out_valid, 0);
      end
    end
    @(negedge clk_tb);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask
  task automatic drain(int mode, int stop, bit chain, int pulses);
    int n = 0, cyc = 0, p = pulses;
    while (n < stop && cyc < 4 * N) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      in_valid = 1'b0;
      in_first = 1'b0;
      if (p > 0 && cyc % 3 == 1) begin
        in_valid = 1'b1;
        in_r = $urandom;
        in_i = $urandom;
        p--;
      end
      if (chain && n == N - 1 && out_ready) begin
        in_valid = 1'b1;
        in_first = 1'b1;
        in_r = fr_r[0];
        in_i = fr_i[0];
      end
      #1;
      check("valid", out_valid, 1);
      check("index", out_index, n);
      check("re", out_r, ex_r[n]);
      check("im", out_i, ex_i[n]);
      check("last", out_last, n == N - 1);
      if (out_ready) n++;
      cyc++;
      @(negedge clk_tb);
    end
    check("drain_count", n, stop);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask
  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk_tb);
    err_clr = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_r = '0;
    in_i = '0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk_tb);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", out_last, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_index", out_index, 0);
    check("rst_re", out_r, 0);
    check("rst_im", out_i, 0);
    rst = 1'b0;
    // ramp frame, full-rate drain, first-output latency
    fill(1);
    set_expected();
    send(0, N - 1, 0, 1);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_index", out_index, 0);
    drain(0, N, 0, 0);
    #1;
    check("s1_idle_valid", out_valid, 0);
    check("s1_idle_busy", busy, 0);
    check("s1_ferr", frame_err, 0);
    check("s1_ovf", overflow, 0);
    // stalled drain with the next frame starting on the final transfer
    fill(0);
    set_expected();
    send(0, N - 1, 0, 1);
    fill(0);
    drain(1, N, 1, 0);
    #1;
    check("s2_ovf", overflow, 0);
    check("s2_busy", busy, 1);
    set_expected();
    send(1, N - 1, 0, 0);
    drain(1, N, 0, 0);
    // input gaps during capture
    fill(1);
    set_expected();
    send(0, N - 1, 3, 1);
    drain(0, N, 0, 0);
    // input during drain
    send(0, N - 1, 0, 1);
    drain(0, N, 0, 5);
    #1;
    check("s4_ovf_set", overflow, 1);
    clear_errors();
    check("s4_ovf_clr", overflow, 0);
    // restart mid-capture
    fill(0);
    send(0, 48, 0, 1);
    fill(0);
    set_expected();
    send(0, N - 1, 0, 1);
    #1;
    check("s5_ferr_set", frame_err, 1);
    drain(0, N, 0, 0);
    clear_errors();
    check("s5_ferr_clr", frame_err, 0);
    // reset mid-capture and mid-drain
    fill(0);
    send(0, 59, 0, 1);
    #1;
    check("s6_busy_cap", busy, 1);
    rst = 1'b1;
    #1;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_valid", out_valid, 0);
    @(negedge clk_tb);
    rst = 1'b0;
    fill(1);
    set_expected();
    send(0, N - 1, 0, 1);
    drain(0, 40, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("s6_drn_valid", out_valid, 0);
    check("s6_drn_busy", busy, 0);
    check("s6_drn_index", out_index, 0);
    check("s6_drn_re", out_r, 0);
    @(negedge clk_tb);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk_tb);
      check("s6_no_xfer", out_valid, 0);
    end
    send(0, N - 1, 0, 1);
    drain(0, N, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
